pipelined_barrel_shifter: RTL and testbench

- Parametrised, multi-mode, fully pipelined barrel shifter. Successor to the 4-bit combinational rotate-left shifter.
- Supports rotate left/right, logical left/right shift and arithmetic right shift on a WIDTH-bit operand.
- One shift stage per amount bit, each stage registered, with a valid/ready handshake on input and output.
- Sits in the datapath between operand-select logic and result writeback; accepts one operation per cycle when not stalled.

---
 rtl/pipelined_barrel_shifter.sv | 116 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter with one registered stage per amount bit and a
// global-stall valid/ready handshake (ROL, ROR, SLL, SRL, SRA; reserved modes pass through).
module pipelined_barrel_shifter #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [2:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] y_o
);

    localparam int unsigned NUM_STAGES = AMT_W;
    localparam int unsigned NUM_MID    = NUM_STAGES - 1;

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    // Beat travelling between stages; amt is pre-shifted so bit 0 always
    // belongs to the stage about to consume it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic [2:0]       mode;
        logic             sign;
    } beat_t;

    beat_t                 mid_q     [NUM_MID];
    logic [NUM_STAGES-1:0] vld_q;
    logic [WIDTH-1:0]      y_q;

    beat_t                 src       [NUM_STAGES];
    logic [NUM_STAGES-1:0] src_vld;
    logic [WIDTH-1:0]      step_data [NUM_STAGES];
    logic                  advance;

    // Fixed-distance shift/rotate applied by one stage; sign is the original operand MSB.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             sign,
        input int unsigned      sh
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (mode)
            MODE_ROL: res = (d << sh) | (d >> (WIDTH - sh));
            MODE_ROR: res = (d >> sh) | (d << (WIDTH - sh));
            MODE_SLL: res = d << sh;
            MODE_SRL: res = d >> sh;
            MODE_SRA: res = (d >> sh) | (sign ? ~(ones >> sh) : '0);
            default:  res = d;
        endcase
        return res;
    endfunction

    assign advance = ~vld_q[NUM_STAGES-1] | ready_i;
    assign ready_o = advance;
    assign valid_o = vld_q[NUM_STAGES-1];
    assign y_o     = y_q;
    assign src_vld = {vld_q[NUM_STAGES-2:0], valid_i};

    // Stage inputs: head beat zeroed when idle so no X ever enters the pipe.
    always_comb begin
        src[0] = '0;
        if (valid_i) begin
            src[0].data = a_i;
            src[0].amt  = amt_i;
            src[0].mode = mode_i;
            src[0].sign = a_i[WIDTH-1];
        end
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            src[k] = mid_q[k-1];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            step_data[k] = src[k].data;
            if (src[k].amt[0]) begin
                step_data[k] = shift_step(src[k].data, src[k].mode, src[k].sign, 32'd1 << k);
            end
        end
    end

    // All stages move together or hold together; bubbles are not squeezed out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NUM_MID; k++) begin
                mid_q[k] <= '0;
            end
            vld_q <= '0;
            y_q   <= '0;
        end else if (advance) begin
            for (int unsigned k = 0; k < NUM_MID; k++) begin
                mid_q[k].data <= step_data[k];
                mid_q[k].amt  <= src[k].amt >> 1;
                mid_q[k].mode <= src[k].mode;
                mid_q[k].sign <= src[k].sign;
            end
            vld_q <= src_vld;
            y_q   <= step_data[NUM_STAGES-1];
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed vector table, throughput,
// backpressure and reset sequences, plus randomized traffic against an arithmetic model.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v8, r8o, vo8, ri8;
    logic [7:0] a8, y8;
    logic [2:0] amt8, mode8;

    logic        v32, r32o, vo32, ri32;
    logic [31:0] a32, y32;
    logic [4:0]  amt32;
    logic [2:0]  mode32;

    int errors = 0;
    int checks = 0;

    pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(r8o), .a_i(a8), .amt_i(amt8),
        .mode_i(mode8), .valid_o(vo8), .ready_i(ri8), .y_o(y8)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(r32o), .a_i(a32), .amt_i(amt32),
        .mode_i(mode32), .valid_o(vo32), .ready_i(ri32), .y_o(y32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a 64-bit value, masked to w bits.
    function automatic logic [31:0] model(input logic [31:0] a, input int amt, input int mode,
                                          input int w);
        longint unsigned mask;
        longint unsigned x;
        longint unsigned r;
        longint          sx;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, a} & mask;
        case (mode)
            0: r = (x << amt) | (x >> (w - amt));
            1: r = (x >> amt) | (x << (w - amt));
            2: r = x << amt;
            3: r = x >> amt;
            4: begin
                sx = longint'(x);
                if (x[w-1]) sx = sx | longint'(~mask);
                r = $unsigned(sx >>> amt);
            end
            default: r = x;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    // Scoreboard for the 8-bit instance; handshakes sampled mid-cycle.
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;
    logic [31:0] sb_model;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (vo8 && ri8) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream unexpected beat: got %h expected none", y8);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("stream y8", 32'(y8), 32'(sb_exp));
                end
            end
            if (v8 && r8o) begin
                sb_model = model(32'(a8), int'(amt8), int'(mode8), 8);
                exp_q.push_back(sb_model[7:0]);
            end
        end
    end

    task automatic send8(input logic [7:0] a, input int amt, input int mode);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        v8 = 1'b1; a8 = a; amt8 = 3'(amt); mode8 = 3'(mode);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = r8o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send8 accept timeout: got ready_o=0 expected 1");
        end
        v8 = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        v8 = 1'b0;
        ri8 = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain queue empty", 32'(exp_q.size()), 32'd0);
        check("drain valid_o idle", 32'(vo8), 32'd0);
    endtask

    task automatic run8(input string name, input logic [7:0] a, input int amt, input int mode,
                        input logic [31:0] exp, input int lat_exp);
        int lat;
        ri8 = 1'b1;
        send8(a, amt, mode);
        lat = 1;
        while (!vo8 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " y_o"}, 32'(y8), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string name, input logic [31:0] a, input int amt, input int mode,
                         input logic [31:0] exp, input int lat_exp);
        int lat;
        check({name, " ready_o"}, 32'(r32o), 32'd1);
        v32 = 1'b1; a32 = a; amt32 = 5'(amt); mode32 = 3'(mode);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        lat = 1;
        while (!vo32 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " y_o"}, y32, exp);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          width;
        logic [31:0] a;
        int          amt;
        int          mode;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] thr_exp [8];

    initial begin
        logic [31:0] ra;
        int          ramt;
        int          rmode;
        logic [31:0] bp_exp;
        int          e;

        vecs[0] = '{8,  32'h0000_00B1, 3, 0, 32'h0000_008D, 3};
        vecs[1] = '{8,  32'h0000_00B1, 3, 1, 32'h0000_0036, 3};
        vecs[2] = '{8,  32'h0000_00B1, 7, 2, 32'h0000_0080, 3};
        vecs[3] = '{8,  32'h0000_00B1, 0, 3, 32'h0000_00B1, 3};
        vecs[4] = '{8,  32'h0000_00B1, 2, 4, 32'h0000_00EC, 3};
        vecs[5] = '{8,  32'h0000_00B1, 5, 7, 32'h0000_00B1, 3};
        vecs[6] = '{32, 32'h8000_0000, 31, 4, 32'hFFFF_FFFF, 5};
        vecs[7] = '{32, 32'h0000_0001, 1, 1, 32'h8000_0000, 5};
        thr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst = 1'b1;
        v8 = 1'b0; a8 = '0; amt8 = '0; mode8 = '0; ri8 = 1'b1;
        v32 = 1'b0; a32 = '0; amt32 = '0; mode32 = '0; ri32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o w8", 32'(vo8), 32'd0);
        check("reset y_o w8", 32'(y8), 32'd0);
        check("reset ready_o w8", 32'(r8o), 32'd1);
        check("reset valid_o w32", 32'(vo32), 32'd0);
        check("reset y_o w32", y32, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].width == 8)
                run8($sformatf("vec%0d", i), vecs[i].a[7:0], vecs[i].amt, vecs[i].mode,
                     vecs[i].exp, vecs[i].lat);
            else
                run32($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].mode,
                      vecs[i].exp, vecs[i].lat);
        end

        // Back-to-back ROL of 0x01 by 0..7: one result per cycle starting after edge 3.
        ri8 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                v8 = 1'b1; a8 = 8'h01; amt8 = 3'(c); mode8 = 3'd0;
            end else begin
                v8 = 1'b0;
            end
            @(posedge clk);
            #1;
            e = c + 1;
            if (e >= 3 && e <= 10) begin
                check($sformatf("thru valid_o e%0d", e), 32'(vo8), 32'd1);
                check($sformatf("thru y_o e%0d", e), 32'(y8), 32'(thr_exp[e-3]));
            end else begin
                check($sformatf("thru idle e%0d", e), 32'(vo8), 32'd0);
            end
        end
        drain8();

        // Exhaustive sweep of amounts and defined modes on 0x96.
        for (int m = 0; m < 5; m++)
            for (int s = 0; s < 8; s++)
                send8(8'h96, s, m);
        drain8();

        // Backpressure: output stalls with three beats inside and a fourth waiting.
        ri8 = 1'b0;
        send8(8'h3C, 1, 0);
        send8(8'hA5, 2, 1);
        send8(8'h81, 3, 4);
        bp_exp = model(32'h3C, 1, 0, 8);
        v8 = 1'b1; a8 = 8'h5A; amt8 = 3'd4; mode8 = 3'd3;
        for (int i = 0; i < 4; i++) begin
            check("bp ready_o", 32'(r8o), 32'd0);
            check("bp valid_o", 32'(vo8), 32'd1);
            check("bp y_o", 32'(y8), bp_exp);
            @(posedge clk);
            #1;
        end
        ri8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        drain8();

        // Reset with beats in flight and one presented on the reset edge.
        ri8 = 1'b1;
        send8(8'h11, 1, 0);
        send8(8'h22, 2, 0);
        v8 = 1'b1; a8 = 8'h33; amt8 = 3'd3; mode8 = 3'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst valid_o", 32'(vo8), 32'd0);
        check("midrst y_o", 32'(y8), 32'd0);
        check("midrst ready_o", 32'(r8o), 32'd1);
        rst = 1'b0;
        v8 = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("post-reset valid_o", 32'(vo8), 32'd0);
        end

        // Random traffic with random backpressure, all modes including reserved.
        for (int i = 0; i < 300; i++) begin
            v8    = ($urandom_range(0, 3) != 0);
            a8    = 8'($urandom);
            amt8  = 3'($urandom_range(0, 7));
            mode8 = 3'($urandom_range(0, 7));
            ri8   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain8();

        for (int i = 0; i < 16; i++) begin
            ra    = $urandom;
            ramt  = int'($urandom_range(0, 31));
            rmode = int'($urandom_range(0, 7));
            run32("rand32", ra, ramt, rmode, model(ra, ramt, rmode, 32), 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
